// File: rtl/final_adder_arbiter_if.sv
// Bus between the final_adder arbiter and its environment: requester
// operands/acks, the shared final_adder operands and the tagged response.
interface final_adder_arbiter_if #(
    parameter int DATA_WIDTH = 1025,
    parameter int NUM_REQ    = 2
);
    localparam int ID_W = $clog2(NUM_REQ);

    // Handshake: requester i raises req_valid[i] with stable operands and may
    // drop it once req_ack[i] pulses; every ack is answered by exactly one
    // rsp_valid pulse carrying rsp_id = i, with rsp_err qualifying rsp_m.
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_s0;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_s1;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_n;
    logic [NUM_REQ-1:0]            req_ack;
    logic                          fa_start;
    logic [DATA_WIDTH-1:0]         fa_s0;
    logic [DATA_WIDTH-1:0]         fa_s1;
    logic [DATA_WIDTH-1:0]         fa_n;
    logic                          fa_done;
    logic [DATA_WIDTH-1:0]         fa_m;
    logic                          rsp_valid;
    logic [ID_W-1:0]               rsp_id;
    logic [DATA_WIDTH-1:0]         rsp_m;
    logic                          rsp_err;
    logic                          busy;
    logic                          spurious_done;

    modport slave (
        input  req_valid, req_s0, req_s1, req_n, fa_done, fa_m,
        output req_ack, fa_start, fa_s0, fa_s1, fa_n,
               rsp_valid, rsp_id, rsp_m, rsp_err, busy, spurious_done
    );

    modport master (
        output req_valid, req_s0, req_s1, req_n, fa_done, fa_m,
        input  req_ack, fa_start, fa_s0, fa_s1, fa_n,
               rsp_valid, rsp_id, rsp_m, rsp_err, busy, spurious_done
    );
endinterface

// File: rtl/final_adder_arbiter.sv
// Round-robin arbiter sharing one final_adder between NUM_REQ requesters,
// with a watchdog that converts a missing fa_done into an error response.
module final_adder_arbiter #(
    parameter int DATA_WIDTH = 1025,
    parameter int NUM_REQ    = 2,
    parameter int TIMEOUT    = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    final_adder_arbiter_if.slave bus,
    output logic [1:0]           dbg_state
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int SUM_W = ID_W + 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [ID_W-1:0]       rr_ptr, win_id, pick_id;
    logic [CNT_W-1:0]      wd_cnt;
    logic                  any_req, done_hit, timeout_hit;
    logic [DATA_WIDTH-1:0] fa_s0_q, fa_s1_q, fa_n_q, rsp_m_q;
    logic [ID_W-1:0]       rsp_id_q;
    logic                  rsp_valid_q, rsp_err_q, spurious_q;

    logic [DATA_WIDTH-1:0] s0_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] s1_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] n_arr  [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign s0_arr[i] = bus.req_s0[i*DATA_WIDTH +: DATA_WIDTH];
        assign s1_arr[i] = bus.req_s1[i*DATA_WIDTH +: DATA_WIDTH];
        assign n_arr[i]  = bus.req_n[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign any_req = |bus.req_valid;

    // Scan offsets from farthest to nearest so the last hit is the first
    // asserted index at or after rr_ptr (modulo NUM_REQ).
    always_comb begin : pick_p
        logic [SUM_W-1:0] sum;
        pick_id = '0;
        sum     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + SUM_W'(k);
            if (sum >= SUM_W'(NUM_REQ)) sum = sum - SUM_W'(NUM_REQ);
            if (bus.req_valid[sum[ID_W-1:0]]) pick_id = sum[ID_W-1:0];
        end
    end

    always_comb begin
        state_nxt   = state;
        done_hit    = 1'b0;
        timeout_hit = 1'b0;
        if (ce) begin
            case (state)
                IDLE:  if (any_req) state_nxt = START;
                START: state_nxt = BUSY;
                BUSY: begin
                    // A done arriving on the last watchdog cycle still wins.
                    if (bus.fa_done) begin
                        state_nxt = IDLE;
                        done_hit  = 1'b1;
                    end else if (wd_cnt == CNT_LAST) begin
                        state_nxt   = IDLE;
                        timeout_hit = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr      <= '0;
            win_id      <= '0;
            wd_cnt      <= '0;
            fa_s0_q     <= '0;
            fa_s1_q     <= '0;
            fa_n_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_id_q    <= '0;
            rsp_m_q     <= '0;
            spurious_q  <= 1'b0;
        end else if (ce) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            if (state == IDLE && any_req) begin
                fa_s0_q <= s0_arr[pick_id];
                fa_s1_q <= s1_arr[pick_id];
                fa_n_q  <= n_arr[pick_id];
                win_id  <= pick_id;
            end
            if (state == START) begin
                wd_cnt <= '0;
            end else if (state == BUSY && !done_hit && !timeout_hit) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (done_hit || timeout_hit) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= timeout_hit;
                rsp_m_q     <= done_hit ? bus.fa_m : '0;
                rsp_id_q    <= win_id;
                rr_ptr      <= (win_id == ID_LAST) ? '0 : win_id + 1'b1;
            end
            if (bus.fa_done && state != BUSY) spurious_q <= 1'b1;
        end
    end

    assign bus.req_ack       = (state == START) ? (NUM_REQ'(1) << win_id) : '0;
    assign bus.fa_start      = (state == START);
    assign bus.fa_s0         = fa_s0_q;
    assign bus.fa_s1         = fa_s1_q;
    assign bus.fa_n          = fa_n_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_id        = rsp_id_q;
    assign bus.rsp_m         = rsp_m_q;
    assign bus.rsp_err       = rsp_err_q;
    assign bus.busy          = (state != IDLE);
    assign bus.spurious_done = spurious_q;
    assign dbg_state         = state;
endmodule
